// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for one ram_arbiter port.
// The requester drives req/we/addr/wdata. The arbiter returns gnt/rvalid/rdata.
interface ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// Serialises CPU (port 0) and loader (port 1) accesses onto one synchronous-read RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_if.slave      m0,
  ram_arbiter_if.slave      m1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              owner;       // 0 = m0, 1 = m1
  logic              last_owner;
  logic              op_we;
  logic              any_req;
  logic              tie_pick;
  logic              pick;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  assign any_req = m0.req | m1.req;

`ifdef RAM_ARB_RR_EN
  assign tie_pick = ~last_owner;
`else
  logic unused_last_owner;
  assign tie_pick          = 1'b0;
  assign unused_last_owner = last_owner;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pick = 1'b0;
    if (m0.req && m1.req) pick = tie_pick;
    else if (m1.req)      pick = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = op_we ? IDLE : WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The winner's request is captured in IDLE, so later changes on req/addr are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      op_we      <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= pick;
        op_we     <= pick ? m1.we    : m0.we;
        ram_addr  <= pick ? m1.addr  : m0.addr;
        ram_wdata <= pick ? m1.wdata : m0.wdata;
      end
      if (state == ISSUE) last_owner <= owner;
    end
  end

  // Read data is on ram_rdata during WAIT. It is latched per port so each port keeps its last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= (state == WAIT) && !owner;
      rvalid1_q <= (state == WAIT) &&  owner;
      if (state == WAIT && !owner) rdata0_q <= ram_rdata;
      if (state == WAIT &&  owner) rdata1_q <= ram_rdata;
    end
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    m0.gnt = 1'b0;
    m1.gnt = 1'b0;
    busy   = (state != IDLE);
    if (state == ISSUE) begin
      ram_en = 1'b1;
      ram_we = op_we;
      m0.gnt = ~owner;
      m1.gnt = owner;
    end
  end

  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus queues expected grants and read returns,
// and a negedge monitor checks them against what the DUT presents.
module tb_ram_arbiter;

  typedef struct packed {
    int          cyc;
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en, ram_we, busy;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic [15:0] mem [0:65535];

  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  bit   mon_en = 1'b0;
  exp_t gnt_q[$];
  exp_t rv_q[$];

  ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m0_if ();
  ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) m1_if ();

  ram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM: data for an ISSUE cycle appears on ram_rdata the next cycle.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    if (p) begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end else begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end
  endtask

  task automatic exp_gnt(input int c, input bit p, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata);
    exp_t e;
    e.cyc = c; e.port = p; e.we = we; e.addr = addr; e.data = wdata;
    gnt_q.push_back(e);
  endtask

  task automatic exp_rv(input int c, input bit p, input logic [15:0] data);
    exp_t e;
    e.cyc = c; e.port = p; e.we = 1'b0; e.addr = '0; e.data = data;
    rv_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic g0, g1, r0, r1;
      g0 = m0_if.gnt; g1 = m1_if.gnt;
      r0 = m0_if.rvalid; r1 = m1_if.rvalid;
      check("ram_en_vs_gnt", {31'd0, ram_en}, {31'd0, g0 | g1});
      if (g0 && g1) begin
        total++; bad++;
        $display("FAIL gnt_both: m0_gnt=1 m1_gnt=1, required at most one (cycle %0d)", cyc);
      end else if (g0 || g1) begin
        if (gnt_q.size() == 0) begin
          total++; bad++;
          $display("FAIL gnt_unexpected: port %0d granted, required no grant (cycle %0d)", g1, cyc);
        end else begin
          e = gnt_q.pop_front();
          check("gnt_cycle", cyc, e.cyc);
          check("gnt_port", {31'd0, g1}, {31'd0, e.port});
          check("gnt_ram_addr", {16'd0, ram_addr}, {16'd0, e.addr});
          check("gnt_ram_we", {31'd0, ram_we}, {31'd0, e.we});
          if (e.we) check("gnt_ram_wdata", {16'd0, ram_wdata}, {16'd0, e.data});
        end
      end else begin
        check("ram_we_outside_issue", {31'd0, ram_we}, 32'd0);
      end
      if (r0 && r1) begin
        total++; bad++;
        $display("FAIL rvalid_both: both rvalid high, required at most one (cycle %0d)", cyc);
      end else if (r0 || r1) begin
        if (rv_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rvalid_unexpected: port %0d rvalid, required none (cycle %0d)", r1, cyc);
        end else begin
          e = rv_q.pop_front();
          check("rv_cycle", cyc, e.cyc);
          check("rv_port", {31'd0, r1}, {31'd0, e.port});
          check("rv_rdata", {16'd0, (r1 ? m1_if.rdata : m0_if.rdata)}, {16'd0, e.data});
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},     {31'd0, busy},         32'd0);
    check({tag, "_ram_en"},   {31'd0, ram_en},       32'd0);
    check({tag, "_ram_we"},   {31'd0, ram_we},       32'd0);
    check({tag, "_ram_addr"}, {16'd0, ram_addr},     32'd0);
    check({tag, "_ram_wdat"}, {16'd0, ram_wdata},    32'd0);
    check({tag, "_gnt"},      {30'd0, m1_if.gnt, m0_if.gnt},       32'd0);
    check({tag, "_rvalid"},   {30'd0, m1_if.rvalid, m0_if.rvalid}, 32'd0);
    check({tag, "_m0_rdata"}, {16'd0, m0_if.rdata},  32'd0);
    check({tag, "_m1_rdata"}, {16'd0, m1_if.rdata},  32'd0);
  endtask

  initial begin
    int n;
    bit p;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0200] = 16'hAAAA;
    mem[16'h0300] = 16'h5555;
    mem[16'h0400] = 16'h4444;
    mem[16'h0500] = 16'h5A5A;
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;

    rst = 1'b1;
    step(3);
    check_reset_values("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Single read by m0: gnt at N+1, rvalid with 0xBEEF at N+3.
    n = cyc;
    drive(1'b0, 1'b0, 16'h0010, 16'h0000);
    exp_gnt(n + 1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    exp_rv(n + 3, 1'b0, 16'hBEEF);
    step(1);
    m0_if.req = 1'b0;
    step(2);
    check("single_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
    check("single_m1_rdata", {16'd0, m1_if.rdata}, 32'd0);
    check("single_m0_rdata", {16'd0, m0_if.rdata}, 32'h0000BEEF);

    // m1 writes 0x1234 to 0x0100 (2-cycle turnaround), then reads it back.
    n = cyc;
    drive(1'b1, 1'b1, 16'h0100, 16'h1234);
    exp_gnt(n + 1, 1'b1, 1'b1, 16'h0100, 16'h1234);
    step(1);
    m1_if.req = 1'b0;
    step(1);
    drive(1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_gnt(n + 3, 1'b1, 1'b0, 16'h0100, 16'h0000);
    exp_rv(n + 5, 1'b1, 16'h1234);
    step(1);
    m1_if.req = 1'b0;
    step(2);
    check("wr_m0_rdata_held", {16'd0, m0_if.rdata}, 32'h0000BEEF);

    // Both ports request reads continuously for four accesses.
    n = cyc;
    drive(1'b0, 1'b0, 16'h0200, 16'h0000);
    drive(1'b1, 1'b0, 16'h0300, 16'h0000);
    for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_RR_EN
      p = k[0];
`else
      p = 1'b0;
`endif
      exp_gnt(n + 1 + 3 * k, p, 1'b0, p ? 16'h0300 : 16'h0200, 16'h0000);
      exp_rv(n + 3 + 3 * k, p, p ? 16'h5555 : 16'hAAAA);
    end
    step(10);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    step(2);

    // m1 raises req during m0's ISSUE: sampled at the next IDLE (N+3), granted at N+4.
    n = cyc;
    drive(1'b0, 1'b0, 16'h0400, 16'h0000);
    exp_gnt(n + 1, 1'b0, 1'b0, 16'h0400, 16'h0000);
    exp_rv(n + 3, 1'b0, 16'h4444);
    step(1);
    m0_if.req = 1'b0;
    drive(1'b1, 1'b0, 16'h0500, 16'h0000);
    exp_gnt(n + 4, 1'b1, 1'b0, 16'h0500, 16'h0000);
    exp_rv(n + 6, 1'b1, 16'h5A5A);
    step(3);
    m1_if.req = 1'b0;
    step(2);

    // Reset during the WAIT of an m0 read: no rvalid, everything back to reset values.
    n = cyc;
    drive(1'b0, 1'b0, 16'h0010, 16'h0000);
    exp_gnt(n + 1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    step(1);
    m0_if.req = 1'b0;
    step(1);
    check("wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step(1);
    check_reset_values("midrst");
    rst = 1'b0;

    // First tie after reset goes to port 0 in either arbitration mode.
    n = cyc;
    drive(1'b0, 1'b0, 16'h0200, 16'h0000);
    drive(1'b1, 1'b0, 16'h0300, 16'h0000);
    exp_gnt(n + 1, 1'b0, 1'b0, 16'h0200, 16'h0000);
    exp_rv(n + 3, 1'b0, 16'hAAAA);
    step(1);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    step(4);

    check("gnt_queue_drained", gnt_q.size(), 32'd0);
    check("rv_queue_drained", rv_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
